display_scan_mux: RTL and testbench
===================================

Name: display_scan_mux

Overview:
- Time-multiplexes a multi-digit hex value onto a single SevenSegment decoder and a shared-segment display.
- Sits directly upstream of the decoder: drives its 4-bit hex input and drives the digit enables for the display.
- Buffers new values in a shadow register and commits them only at frame boundaries, so a digit never shows a mix of old and new data.

Parameters:
- NUM_DIGITS, 4, number of display digits (1..8).
- REFRESH_DIV, 50000, clk cycles each digit stays selected (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- value  in  4*NUM_DIGITS  hex digits to show; nibble i is digit i, digit 0 is rightmost
- load  in  1  capture value into shadow register this cycle
- pending  out  1  shadow holds a value not yet committed to the display
- frame_start  out  1  one-cycle pulse when scanning wraps back to digit 0
- hex  out  4  nibble for the currently selected digit; connects to SevenSegment hex
- digit_en  out  NUM_DIGITS  one-hot, active-high digit select

Behaviour:
- One clock; reset is synchronous and active-high, sampled on the rising clk edge.
- Reset values:
  - prescaler cnt=0, idx=0, disp=0, shadow=0, pending=0.
  - Outputs: hex=0, digit_en=1 (digit 0 selected), frame_start=0, pending=0.
- Prescaler:
  - cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick=1 in the cycle where cnt==REFRESH_DIV-1.
  - With REFRESH_DIV=1, tick is high every cycle.
- Digit index: on tick, idx advances by 1 and wraps from NUM_DIGITS-1 to 0.
- Frame wrap event: tick && idx==NUM_DIGITS-1.
  - Next cycle: idx=0 and frame_start=1 for exactly one cycle.
- Load:
  - load=1 captures shadow<=value and sets pending<=1 on the next edge.
  - Repeated loads before commit overwrite shadow; the last value wins.
- Commit: on a frame wrap event with pending=1, disp<=shadow and pending<=0.
- Load and commit in the same cycle: disp<=old shadow, shadow<=new value, pending remains 1. The new value commits at the next frame wrap.
- Outputs:
  - hex = disp[4*idx+3 : 4*idx]; digit_en = 1<<idx.
  - Both are decoded from registers only (no input-to-output combinational path).
- Latency: a load lands on the display at the first frame wrap strictly after the load edge. Worst case is NUM_DIGITS*REFRESH_DIV+1 cycles.
- Reset mid-frame: scanning restarts at digit 0, shadow and disp clear, and any pending load is discarded.

Optional Feature:
- Macro: DISPLAY_SCAN_MUX_ZERO_BLANK_EN.
- With the macro defined:
  - digit_en bit i (i>0) is forced 0 while disp nibbles NUM_DIGITS-1 down to i are all zero (leading-zero blanking).
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - hex output and scan timing are unchanged.
- Without the macro: every digit is enabled in its slot, including leading zeros.

Decomposition:
- Shared package disp_pkg holds:
  - NIBBLE_W=4
  - MAX_DIGITS=8
  - the default REFRESH_DIV constant
  - a function returning ceil-log2 widths for the cnt and idx counters
- One natural sub-module: refresh_prescaler (parameter REFRESH_DIV; ports clk, reset, tick).
- The scan, shadow and commit logic stays in display_scan_mux.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4 unless noted):
- Reset:
  - Stimulus: hold reset 3 cycles, then release.
  - Required: hex=0, digit_en=0001, pending=0; digit_en steps 0001→0010→0100→1000 every 4 cycles; frame_start pulses every 16 cycles.
- Load and commit:
  - Stimulus: pulse load with value=16'h1A2F mid-frame.
  - Required: pending=1 until the next frame_start; after it, hex reads F,2,A,1 on digits 0..3 in turn.
- Load at the frame wrap edge:
  - Stimulus: load value=16'h00FF in the same cycle as the wrap tick, with an earlier 16'h1234 already pending.
  - Required: the next frame displays 1234; pending stays 1; the following frame displays 00FF and pending clears.
- Reset mid-operation:
  - Stimulus: load 16'hBEEF, then assert reset before the frame wrap.
  - Required: BEEF is never displayed; disp=0 and pending=0.
- REFRESH_DIV=1:
  - Stimulus: run with REFRESH_DIV=1.
  - Required: digit_en changes every cycle; frame_start pulses every 4 cycles.
- DISPLAY_SCAN_MUX_ZERO_BLANK_EN defined:
  - Stimulus: commit value 16'h0030.
  - Required: digits 3 and 2 have digit_en=0; digits 1 and 0 enabled. With value 16'h0000, only digit 0 is enabled.

Source files
------------

// File: rtl/display_scan_mux_pkg.sv
// Shared constants and width helper for the display scan multiplexer slice.
// Package name is disp_pkg; all display files import it.
package disp_pkg;

  localparam int NIBBLE_W            = 4;
  localparam int MAX_DIGITS          = 8;
  localparam int DEFAULT_REFRESH_DIV = 50000;

  // Ceil-log2 width for a counter holding 0..n-1, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/display_scan_mux_if.sv
// Bus between the value producer and the display scan multiplexer.
// load is a single-cycle qualifier on value with no ready: the mux always accepts it.
interface display_scan_mux_if
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic [NIBBLE_W*NUM_DIGITS-1:0] value;
  logic                           load;
  logic                           pending;
  logic                           frame_start;
  logic [NIBBLE_W-1:0]            hex;
  logic [NUM_DIGITS-1:0]          digit_en;

  modport master (
    output value,
    output load,
    input  pending,
    input  frame_start,
    input  hex,
    input  digit_en
  );

  modport slave (
    input  value,
    input  load,
    output pending,
    output frame_start,
    output hex,
    output digit_en
  );

endinterface

// File: rtl/display_scan_mux_prescaler.sv
// Refresh prescaler: tick is high for one cycle out of every REFRESH_DIV.
// tick is decoded straight from the count register.
module refresh_prescaler
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int            CW   = cnt_width(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexes a multi-digit hex value onto one seven-segment decoder.
// Optional leading-zero blanking: define DISPLAY_SCAN_MUX_ZERO_BLANK_EN.
module display_scan_mux
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
  input  logic               clk,
  input  logic               reset,
  display_scan_mux_if.slave  bus
);

  localparam int            IW       = cnt_width(NUM_DIGITS);
  localparam int            DW       = NIBBLE_W * NUM_DIGITS;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  logic          tick;
  logic          wrap;
  logic [IW-1:0] idx;
  logic [DW-1:0] shadow;
  logic [DW-1:0] disp;
  logic          pending_q;
  logic          frame_start_q;
  logic          blank;

  refresh_prescaler #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign wrap = tick && (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      idx           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= wrap;
      if (wrap) begin
        idx <= '0;
      end else if (tick) begin
        idx <= idx + IW'(1);
      end
    end
  end

  // A load in the commit cycle lands in shadow after the old shadow moves to
  // disp, so the later pending assignment keeps the new value queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow    <= '0;
      disp      <= '0;
      pending_q <= 1'b0;
    end else begin
      if (wrap && pending_q) begin
        disp      <= shadow;
        pending_q <= 1'b0;
      end
      if (bus.load) begin
        shadow    <= bus.value;
        pending_q <= 1'b1;
      end
    end
  end

  always_comb begin
    blank = 1'b0;
`ifdef DISPLAY_SCAN_MUX_ZERO_BLANK_EN
    if (idx != '0) begin
      blank = ((disp >> (int'(idx) * NIBBLE_W)) == '0);
    end
`endif
    bus.hex         = disp[int'(idx) * NIBBLE_W +: NIBBLE_W];
    bus.digit_en    = blank ? '0 : (NUM_DIGITS'(1) << idx);
    bus.pending     = pending_q;
    bus.frame_start = frame_start_q;
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: two instances (REFRESH_DIV 4 and 1) against a
// time-based reference model, directed scenarios followed by random loads/resets.
module tb_display_scan_mux;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  display_scan_mux_if #(.NUM_DIGITS(N)) bus_a ();
  display_scan_mux_if #(.NUM_DIGITS(N)) bus_b ();

  display_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(4)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  display_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // Reference model: t counts cycles since reset; scan position and frame
  // boundaries follow from t by division, display content from load history.
  int          rdiv [2] = '{4, 1};
  int          t    [2];
  logic [15:0] m_shadow [2];
  logic [15:0] m_disp   [2];
  bit          m_pend   [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int d, input bit rst, input bit ld, input logic [15:0] v);
    int frame;
    frame = N * rdiv[d];
    if (rst) begin
      t[d]        = 0;
      m_shadow[d] = '0;
      m_disp[d]   = '0;
      m_pend[d]   = 1'b0;
    end else begin
      if (((t[d] + 1) % frame) == 0 && m_pend[d]) begin
        m_disp[d] = m_shadow[d];
        m_pend[d] = 1'b0;
      end
      if (ld) begin
        m_shadow[d] = v;
        m_pend[d]   = 1'b1;
      end
      t[d]++;
    end
  endtask

  function automatic int exp_idx(input int d);
    return (t[d] / rdiv[d]) % N;
  endfunction

  function automatic logic [3:0] exp_hex(input int d);
    return 4'((m_disp[d] >> (4 * exp_idx(d))) & 16'hF);
  endfunction

  function automatic logic [3:0] exp_en(input int d);
    int i;
    i = exp_idx(d);
`ifdef DISPLAY_SCAN_MUX_ZERO_BLANK_EN
    if (i > 0 && (m_disp[d] >> (4 * i)) == 16'h0) return 4'b0000;
`endif
    return 4'(1 << i);
  endfunction

  function automatic bit exp_fs(input int d);
    return (t[d] > 0) && ((t[d] % (N * rdiv[d])) == 0);
  endfunction

  task automatic check_one(input string name, input int d, input logic [3:0] hex,
                           input logic [3:0] en, input logic pend, input logic fs);
    check_eq({name, ".hex"},         32'(hex),  32'(exp_hex(d)));
    check_eq({name, ".digit_en"},    32'(en),   32'(exp_en(d)));
    check_eq({name, ".pending"},     32'(pend), 32'(m_pend[d]));
    check_eq({name, ".frame_start"}, 32'(fs),   32'(exp_fs(d)));
  endtask

  // Inputs are applied before the edge, model advances at the edge,
  // outputs are compared on the falling edge.
  task automatic do_cycle(input bit rst, input bit ld, input logic [15:0] v);
    reset       = rst;
    bus_a.load  = ld;
    bus_b.load  = ld;
    bus_a.value = v;
    bus_b.value = v;
    @(posedge clk);
    model_step(0, rst, ld, v);
    model_step(1, rst, ld, v);
    @(negedge clk);
    check_one("div4", 0, bus_a.hex, bus_a.digit_en, bus_a.pending, bus_a.frame_start);
    check_one("div1", 1, bus_b.hex, bus_b.digit_en, bus_b.pending, bus_b.frame_start);
    bus_a.load = 1'b0;
    bus_b.load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 16'h0);
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 16 && (t[0] % 16) != ph; i++) do_cycle(1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    reset       = 1'b1;
    bus_a.load  = 1'b0;
    bus_b.load  = 1'b0;
    bus_a.value = '0;
    bus_b.value = '0;

    repeat (3) do_cycle(1'b1, 1'b0, 16'h0);
    idle(40);

    wait_phase(6);
    do_cycle(1'b0, 1'b1, 16'h1A2F);
    idle(40);

    wait_phase(3);
    do_cycle(1'b0, 1'b1, 16'h1234);
    wait_phase(15);
    do_cycle(1'b0, 1'b1, 16'h00FF);
    idle(40);

    wait_phase(2);
    do_cycle(1'b0, 1'b1, 16'hBEEF);
    idle(2);
    do_cycle(1'b1, 1'b0, 16'h0);
    do_cycle(1'b1, 1'b0, 16'h0);
    idle(40);

    do_cycle(1'b0, 1'b1, 16'h0030);
    idle(40);
    do_cycle(1'b0, 1'b1, 16'h0000);
    idle(40);
    do_cycle(1'b0, 1'b1, 16'hF00D);
    idle(20);

    for (int i = 0; i < 2000; i++) begin
      logic        r;
      logic        l;
      logic [15:0] v;
      r = ($urandom_range(0, 299) == 0);
      l = ($urandom_range(0, 9) == 0);
      v = 16'($urandom);
      if ($urandom_range(0, 3) == 0) v = v & 16'h00F0;
      do_cycle(r, l, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
